// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a DEPTH-entry skid queue.
// in_ready depends only on the registered occupancy, so upstream can keep
// issuing for DEPTH cycles after downstream stalls. flush squashes the queue
// and a saturating counter records how many entries were thrown away.
module pipe_skid_stage #(
   parameter int                 WIDTH            = 128,
   parameter int                 DEPTH            = 2,
   parameter int                 CLEAR_ON_INVALID = 1,
   parameter logic [WIDTH-1:0]   BUBBLE_VAL       = '0,
   parameter int                 CNT_W            = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_W-1:0]             drop_cnt
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   // Wide enough that drop_cnt + count + push can never wrap before the clamp.
   localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 2;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic             push;
   logic             pop;

   // Clamp the squashed-entry tally at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                input logic [CW-1:0]    n,
                                                input logic             inc);
      logic [SW-1:0] sum;
      sum = SW'(acc) + SW'(n) + SW'(inc);
      if (sum > SW'({CNT_W{1'b1}}))
         return {CNT_W{1'b1}};
      else
         return sum[CNT_W-1:0];
   endfunction

   // Full/empty come from count only; pointer equality is ambiguous.
   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0) && !flush;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = (out_valid || (CLEAR_ON_INVALID == 0)) ? mem[rp] : BUBBLE_VAL;

   // Payload storage is never reset; only the pointers and count qualify it.
   always_ff @(posedge clk) begin
      if (push)
         mem[wp] <= in_data;
   end

   // Pointers, occupancy and drop counter; rst beats flush beats transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else if (flush) begin
         // A push accepted during flush is written but immediately skipped.
         wp       <= wp + PW'(push);
         rp       <= wp + PW'(push);
         count    <= '0;
         drop_cnt <= sat_add(drop_cnt, count, push);
      end else begin
         if (push)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a DEPTH=2/CNT_W=4 instance and a DEPTH=4 instance,
// each checked every cycle against a queue-based model of the handshake rules.
module tb_pipe_skid_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // DEPTH=2 instance
   logic        fl2 = 0, iv2 = 0, or2 = 0;
   logic [15:0] id2 = '0;
   logic        ir2, ov2;
   logic [15:0] od2;
   logic [1:0]  cnt2;
   logic [3:0]  drp2;

   // DEPTH=4 instance
   logic        fl4 = 0, iv4 = 0, or4 = 0;
   logic [15:0] id4 = '0;
   logic        ir4, ov4;
   logic [15:0] od4;
   logic [2:0]  cnt4;
   logic [15:0] drp4;

   pipe_skid_stage #(.WIDTH(16), .DEPTH(2), .CLEAR_ON_INVALID(1),
                     .BUBBLE_VAL(16'h0000), .CNT_W(4)) u_d2 (
      .clk(clk), .rst(rst), .flush(fl2),
      .in_valid(iv2), .in_ready(ir2), .in_data(id2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2),
      .count(cnt2), .drop_cnt(drp2));

   pipe_skid_stage #(.WIDTH(16), .DEPTH(4), .CLEAR_ON_INVALID(1),
                     .BUBBLE_VAL(16'hBEEF), .CNT_W(16)) u_d4 (
      .clk(clk), .rst(rst), .flush(fl4),
      .in_valid(iv4), .in_ready(ir4), .in_data(id4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4),
      .count(cnt4), .drop_cnt(drp4));

   int checks   = 0;
   int failures = 0;

   // Reference model: contents in order, plus the squash tally.
   logic [15:0] mq[$];
   int          mdrop;
   int          mdepth;
   int          mmax;
   logic [15:0] mbubble;
   int          sel;
   bit          acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, compare 1 time unit later, advance model.
   task automatic step(input bit v, input logic [15:0] d, input bit f, input bit ordy);
      logic [31:0] o_v, o_d, o_r, o_c, o_x;
      int  e_cnt;
      bit  e_rdy, e_vld, e_push, e_pop;
      logic [15:0] e_dat;
      if (sel == 2) begin
         iv2 = v; id2 = d; fl2 = f; or2 = ordy;
         iv4 = 0; fl4 = 0; or4 = 0;
      end else begin
         iv4 = v; id4 = d; fl4 = f; or4 = ordy;
         iv2 = 0; fl2 = 0; or2 = 0;
      end
      #1;
      if (sel == 2) begin
         o_v = 32'(ov2); o_d = 32'(od2); o_r = 32'(ir2); o_c = 32'(cnt2); o_x = 32'(drp2);
      end else begin
         o_v = 32'(ov4); o_d = 32'(od4); o_r = 32'(ir4); o_c = 32'(cnt4); o_x = 32'(drp4);
      end
      e_cnt  = mq.size();
      e_rdy  = (e_cnt != mdepth);
      e_vld  = (e_cnt != 0) && !f;
      e_dat  = e_vld ? mq[0] : mbubble;
      e_push = v && e_rdy;
      e_pop  = e_vld && ordy;
      chk("out_valid", o_v, 32'(e_vld));
      chk("out_data",  o_d, 32'(e_dat));
      chk("in_ready",  o_r, 32'(e_rdy));
      chk("count",     o_c, 32'(e_cnt));
      chk("drop_cnt",  o_x, 32'(mdrop));
      if (f) begin
         mdrop = mdrop + e_cnt + int'(e_push);
         if (mdrop > mmax) mdrop = mmax;
         mq.delete();
      end else begin
         if (e_pop)  void'(mq.pop_front());
         if (e_push) mq.push_back(d);
      end
      acc = e_push;
      @(negedge clk);
   endtask

   // Two reset cycles with valid and flush both asserted; everything must clear.
   task automatic do_reset();
      rst = 1;
      iv2 = 1; fl2 = 1; iv4 = 1; fl4 = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      iv2 = 0; fl2 = 0; iv4 = 0; fl4 = 0;
      mq.delete();
      mdrop = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          pv;
      logic [15:0] pd;
      int          k;

      // ---------- DEPTH=2, CNT_W=4 ----------
      sel = 2; mdepth = 2; mmax = 15; mbubble = 16'h0000;
      @(negedge clk);
      do_reset();
      step(0, 16'h0, 0, 0);                      // post-reset state

      // Streaming 0x11..0x18 with out_ready held high
      for (int i = 0; i < 8; i++) step(1, 16'(8'h11 + i), 0, 1);
      step(0, 16'h0, 0, 1);
      step(0, 16'h0, 0, 1);

      // Backpressure: A, B fill the queue, C waits until a slot frees
      step(1, 16'h00A0, 0, 0);
      step(1, 16'h00B0, 0, 0);
      step(1, 16'h00C0, 0, 0);
      step(1, 16'h00C0, 0, 0);
      step(1, 16'h00C0, 0, 1);
      step(1, 16'h00C0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 1);

      // Saturation: 8 flushes of 2 entries each, tally clamps at 15
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, 16'(16'h0100 + i), 0, 0);
         step(1, 16'(16'h0200 + i), 0, 0);
         step(0, 16'h0, 1, 0);
      end
      step(0, 16'h0, 0, 0);
      step(1, 16'h0300, 1, 0);                   // one more squashed push, still 15
      step(0, 16'h0, 0, 0);

      // ---------- DEPTH=4, CNT_W=16, bubble 0xBEEF ----------
      sel = 4; mdepth = 4; mmax = 65535; mbubble = 16'hBEEF;
      do_reset();
      step(0, 16'h0, 0, 0);

      // Flush with two entries queued plus a push in the same cycle
      step(1, 16'h0A0A, 0, 0);
      step(1, 16'h0B0B, 0, 0);
      step(1, 16'h0C0C, 1, 1);
      step(0, 16'h0, 0, 0);
      step(1, 16'h0D0D, 0, 0);
      step(0, 16'h0, 0, 1);
      // Back-to-back flushes: second adds nothing
      step(1, 16'h0E0E, 0, 0);
      step(0, 16'h0, 1, 0);
      step(0, 16'h0, 1, 0);
      step(0, 16'h0, 0, 0);

      // Wrap-around: 10 pushes interleaved with pops at occupancies 1..4
      k = 0;
      for (int c = 0; c < 24; c++) begin
         step(k < 10, 16'(16'h0040 + k), 0, (c >= 4) && ((c % 2 == 1) || (c >= 14)));
         if (acc) k++;
      end

      // Randomized traffic with occasional flush; data held while stalled
      pv = 0; pd = '0;
      for (int c = 0; c < 400; c++) begin
         bit f, o;
         if (!pv) begin
            pv = ($urandom_range(0, 3) != 0);
            pd = 16'($urandom);
         end
         f = ($urandom_range(0, 15) == 0);
         o = ($urandom_range(0, 2) != 0);
         step(pv, pd, f, o);
         if (acc) pv = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, ...). It replaces fixed load/flush latches with a valid/ready handshake and a DEPTH-entry skid queue.
- Upstream can keep issuing for DEPTH cycles after downstream stalls, so ready never combinationally depends on out_ready.
- Flush squashes all queued entries and inserts bubbles.
- A saturating counter reports squashed entries for performance analysis.

Parameters:
- WIDTH, 128, payload bits per entry (packed pc, pc+4, opcode, functs, regs, immediates, ...).
- DEPTH, 2, queue entries; power of two, >= 2.
- CLEAR_ON_INVALID, 1, 1 = out_data driven to BUBBLE_VAL whenever out_valid=0; 0 = out_data shows the raw head slot.
- BUBBLE_VAL, '0, WIDTH-bit bubble/NOP encoding.
- CNT_W, 16, width of drop_cnt.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all contents (branch/jump redirect).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  queue can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid for downstream.
- out_ready  in  1  downstream consumes head this cycle.
- out_data  out  WIDTH  head payload (or BUBBLE_VAL, see below).
- count  out  $clog2(DEPTH+1)  occupied entries (registered).
- drop_cnt  out  CNT_W  saturating count of entries squashed by flush.

Behaviour:
- Storage: circular buffer of DEPTH x WIDTH, write pointer wp, read pointer rp (log2(DEPTH) bits, natural wrap), registered count.
- Reset (rst=1 at posedge): wp=rp=0, count=0, drop_cnt=0. Storage contents need not be cleared.
  - After reset: out_valid=0, out_data=BUBBLE_VAL (when CLEAR_ON_INVALID=1), in_ready=1.
  - rst has priority over flush and all transfers.
- in_ready = (count != DEPTH). It is a function of registered state only, with no combinational path from out_ready or flush.
- out_valid = (count != 0) && !flush.
- out_data = storage[rp] when out_valid=1. Otherwise BUBBLE_VAL if CLEAR_ON_INVALID=1, else storage[rp].
- push = in_valid && in_ready. On push: storage[wp] <= in_data, wp <= wp+1.
- pop = out_valid && out_ready. On pop: rp <= rp+1.
- count' = count + push - pop.
- Latency: an entry pushed at cycle N is visible on out_valid/out_data at cycle N+1 (one-cycle stage, same as a plain pipeline register).
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Simultaneous push and pop:
  - Allowed at any count with 0 < count < DEPTH; count unchanged.
  - At count=DEPTH only pop occurs (in_ready=0).
  - At count=0 only push occurs (out_valid=0).
- Flush (flush=1, rst=0):
  - Same cycle: out_valid forced 0, so no pop. in_ready is unaffected, but any push that cycle is discarded.
  - Next state: rp <= wp + push, count <= 0.
  - drop_cnt <= min(drop_cnt + count + push, 2^CNT_W - 1), saturating with no wrap.
  - Following cycle: out_valid=0, in_ready=1.
- Back-to-back flushes: each cycle clears the queue and adds that cycle's count+push (0 after the first, unless pushes occur).
- Pointer wrap: wp/rp wrap modulo DEPTH; ordering is preserved across the wrap.
- Full/empty: determined by count only, never by pointer equality.
- Reset mid-operation: all in-flight entries are lost. drop_cnt clears and does not count them.
- Assertions (bench):
  - in_data must be held stable while in_valid=1 && in_ready=0.
  - out_data must be stable while out_valid=1 && out_ready=0 (absent flush).

Test Plan:
- Reset: assert rst 2 cycles while in_valid=1 and flush=1 -> after release: count=0, drop_cnt=0, out_valid=0, out_data=0, in_ready=1.
- Streaming: push 0x11..0x18 on consecutive cycles with out_ready=1 -> each value appears one cycle after push, in order. count stays 1, in_ready never drops.
- Backpressure (DEPTH=2): out_ready=0, push A, B, C -> count=2 after B, in_ready=0, C held. Then out_ready=1 -> pops A, B, C in order, with C accepted the cycle after count drops to 1.
- Flush with entries: count=2 (A, B) plus push of C in the same cycle as flush -> out_valid=0 that cycle; next cycle count=0, out_data=BUBBLE_VAL, drop_cnt=3. Next push D is the next output.
- Wrap-around (DEPTH=4): 10 pushes interleaved with pops at count 1..4 -> output order matches input, count matches the model every cycle.
- Saturation (CNT_W=4): 8 flushes each squashing 2 entries -> drop_cnt climbs to 15 and holds at 15.
